// File: rtl/serial_link_pkg.sv
// Shared definitions for the single-wire serial link (TX and RX sides).
// State encoding, line levels and the frame-length helper live here.
package serial_link_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Total clock cycles occupied by one frame on the wire.
  function automatic int frame_cycles(input int data_w, input int clks_per_bit,
                                      input int parity_en, input int stop_bits);
    return clks_per_bit * (1 + data_w + parity_en + stop_bits);
  endfunction

endpackage

// File: rtl/serial_frame_tx_bit_timer.sv
// Bit-time cycle counter: tick is high in the last cycle of each bit-time.
// Held at zero while disabled so a new frame always starts on a bit boundary.
module bit_timer #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst || !en) begin
      cnt_reg <= '0;
    end else if (cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, LSB-first data, optional even parity,
// one or two stop bits. Word accepted over valid/ready only while idle.
module serial_frame_tx
  import serial_link_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int STOP_BITS    = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int BW = $clog2(DATA_W) + 1;
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_W - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

  state_t            state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] shift_next;
  logic              parity_reg;
  logic [BW-1:0]     bit_cnt_reg;
  logic              tx_reg;
  logic              timer_en;
  logic              tick;

  assign timer_en   = (state_reg != IDLE);
  assign shift_next = shift_reg >> 1;

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk  (clk),
    .rst  (rst),
    .en   (timer_en),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      bit_cnt_reg <= '0;
      tx_reg      <= LINE_IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          tx_reg <= LINE_IDLE;
          if (in_valid && in_ready) begin
            shift_reg  <= in_data;
            // Parity is taken from the captured word because shift_reg is consumed.
            parity_reg <= ^in_data;
            state_reg  <= START;
            tx_reg     <= LINE_START;
          end
        end
        START: begin
          if (tick) begin
            state_reg   <= DATA;
            bit_cnt_reg <= '0;
            tx_reg      <= shift_reg[0];
          end
        end
        DATA: begin
          if (tick) begin
            shift_reg <= shift_next;
            if (bit_cnt_reg == LAST_DATA) begin
              bit_cnt_reg <= '0;
              if (PARITY_EN != 0) begin
                state_reg <= PARITY;
                tx_reg    <= parity_reg;
              end else begin
                state_reg <= STOP;
                tx_reg    <= LINE_IDLE;
              end
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
              tx_reg      <= shift_next[0];
            end
          end
        end
        PARITY: begin
          if (tick) begin
            state_reg   <= STOP;
            bit_cnt_reg <= '0;
            tx_reg      <= LINE_IDLE;
          end
        end
        STOP: begin
          tx_reg <= LINE_IDLE;
          if (tick) begin
            if (bit_cnt_reg == LAST_STOP) begin
              state_reg <= IDLE;
            end else begin
              bit_cnt_reg <= bit_cnt_reg + BW'(1);
            end
          end
        end
        default: begin
          state_reg <= IDLE;
          tx_reg    <= LINE_IDLE;
        end
      endcase
    end
  end

  assign in_ready   = (state_reg == IDLE);
  assign busy       = (state_reg != IDLE);
  assign frame_done = (state_reg == STOP) && tick && (bit_cnt_reg == LAST_STOP);
  assign tx_out     = tx_reg;

endmodule

// File: doc/serial_frame_tx.md
Name: serial_frame_tx

Overview:
- Transmit end of the single-wire serial link whose receiver samples one bit per clock event into a registered output.
- Accepts a parallel word over a valid/ready handshake and serializes it as one frame on `tx_out`: start bit, data LSB-first, optional even parity, stop bit(s).
- Sits between testbench/core stimulus logic and the sampling receiver.
- Verified with X-propagation enabled on this module only; outputs must be X-free once reset has been applied with known inputs.

Parameters:
- DATA_W, 8, data bits per frame (1..16).
- CLKS_PER_BIT, 4, clock cycles each bit is held on `tx_out` (>=1).
- PARITY_EN, 1, 1 = append even-parity bit after data; 0 = none.
- STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  word offered.
- in_ready  output  1  block can accept a word (high only in IDLE).
- in_data  input  DATA_W  word to send; sampled only on handshake.
- tx_out  output  1  serial line, idle/stop = 1, start = 0.
- busy  output  1  frame in progress (state != IDLE).
- frame_done  output  1  one-cycle pulse in the last cycle of the final stop bit.

Behaviour:
- Reset (rst=1 at a rising edge):
  - state=IDLE, tx_out=1, busy=0, frame_done=0, in_ready=1 from the next cycle.
  - Bit counter and cycle counter cleared; shift register cleared to 0.
  - rst dominates every other input.
  - Reset mid-frame aborts immediately: tx_out returns to 1 and the partial frame is not completed.
- Handshake:
  - Accept occurs when in_valid && in_ready at a rising edge.
  - in_data is captured into the shift register at that edge.
  - in_ready = (state==IDLE); it is a combinational decode of the state register only, with no path from in_valid.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on accept.
  - START -> DATA after CLKS_PER_BIT cycles.
  - DATA -> PARITY (PARITY_EN=1) or STOP (PARITY_EN=0) after DATA_W bit-times.
  - PARITY -> STOP after one bit-time.
  - STOP -> IDLE after STOP_BITS bit-times.
- tx_out is registered and is driven from the state/shift register:
  - START: 0.
  - DATA: shift_reg[0]; the register shifts right once per bit-time.
  - PARITY: XOR-reduce of the captured word (even parity).
  - STOP and IDLE: 1.
- Latency:
  - tx_out falls in the cycle immediately after the accepting edge.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - Frame length in cycles = CLKS_PER_BIT*(1+DATA_W+PARITY_EN+STOP_BITS).
- Back-to-back frames:
  - frame_done is high in the final STOP cycle; the state is IDLE on the following cycle.
  - A new accept is possible in that IDLE cycle, so the minimum gap between frames is exactly one cycle of tx_out=1 beyond the stop bit(s).
- in_valid while busy: ignored; no capture, no error. The source must hold in_valid until in_ready.
- Counters:
  - Cycle counter width is clog2(CLKS_PER_BIT)+1 bits; it wraps to 0 at CLKS_PER_BIT-1 on every bit boundary.
  - Bit counter width is clog2(DATA_W)+1 bits; it resets to 0 on entry to DATA and on entry to STOP.
- X-handling:
  - If in_data contains X at accept, the X may appear on tx_out only during DATA/PARITY bit-times.
  - Control (state, busy, in_ready, frame_done) must never go X after reset provided rst, in_valid and in_ready-qualified inputs are known.
  - An X on in_valid while IDLE is a bench error.

Decomposition:
- Shared package `serial_link_pkg` holds:
  - state enum/localparams: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4;
  - line levels LINE_IDLE=1'b1, LINE_START=1'b0;
  - function frame_cycles(DATA_W, CLKS_PER_BIT, PARITY_EN, STOP_BITS), shared by the TX and RX benches.
- One sub-module is natural: `bit_timer`, holding the cycle counter with a tick output asserted on the last cycle of each bit-time. It is reused by the receiver.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, in_valid=0 -> tx_out=1, busy=0, in_ready=1, frame_done=0 for 10 cycles, with no X on any output.
- Single frame with defaults (8, 4, parity on, 1 stop), in_data=8'hA5 accepted at cycle T:
  - tx_out = 0 for cycles T+1..T+4;
  - then data bits 1,0,1,0,0,1,0,1 at 4 cycles each;
  - then parity 0 for 4 cycles, then stop 1 for 4 cycles;
  - frame_done pulses at T+44, in_ready=1 at T+45.
- Back-to-back: in_valid held high with 8'h01 then 8'hFF -> second start bit begins exactly 2 cycles after the first frame_done; parity bits 1 and 0 respectively.
- Parameter sweep (CLKS_PER_BIT=1, PARITY_EN=0, STOP_BITS=2), in_data=8'h80 -> frame is 11 cycles, pattern 0,0000000 1,1,1 (LSB first); frame_done fires in cycle 11.
- Reset mid-frame: rst asserted at bit 3 of DATA -> next cycle tx_out=1, busy=0, in_ready=1; a new word 8'h3C is then sent cleanly.
- X-prop check: rst=X during the first 2 cycles followed by rst=1 -> after the rst=1 edge all control outputs are known. in_data=8'bxxxx0000 -> X appears on tx_out only during data bits 4..7 and the parity bit.
